// File: rtl/branch_pc_sequencer_pkg.sv
// Shared constants and types for the per-thread branch PC sequencer.
package branch_pc_sequencer_pkg;

   localparam int unsigned PC_WIDTH_DEFAULT           = 10;
   localparam int unsigned THREAD_COUNT_DEFAULT       = 8;
   localparam int unsigned THREAD_COUNT_WIDTH_DEFAULT = 3;
   localparam int unsigned DETECTOR_COUNT_DEFAULT     = 4;

   typedef enum logic [1:0] {
      SRC_INC,
      SRC_JUMP,
      SRC_HOLD,
      SRC_OVERRIDE
   } pc_src_e;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned index_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/branch_pc_sequencer_priority_select.sv
// Lowest-index priority encoder over the branch detectors.
module branch_priority_select
   import branch_pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_WIDTH       = PC_WIDTH_DEFAULT,
   parameter int unsigned DETECTOR_COUNT = DETECTOR_COUNT_DEFAULT,
   parameter int unsigned INDEX_WIDTH    = index_width(DETECTOR_COUNT)
)(
   input  logic [DETECTOR_COUNT-1:0]          valid,
   input  logic [DETECTOR_COUNT*PC_WIDTH-1:0] destination,
   output logic [INDEX_WIDTH-1:0]             winner,
   output logic                               any_jump,
   output logic [PC_WIDTH-1:0]                winner_destination
);

   always_comb begin
      winner             = '0;
      any_jump           = 1'b0;
      winner_destination = '0;
      for (int unsigned i = 0; i < DETECTOR_COUNT; i++) begin
         if (valid[i] && !any_jump) begin
            any_jump           = 1'b1;
            winner             = INDEX_WIDTH'(i);
            winner_destination = destination[i*PC_WIDTH +: PC_WIDTH];
         end
      end
   end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Barrel-pipeline fetch sequencer: rotating per-thread PC ring with branch,
// annul-hold, sequential and external-override next-PC sources.
module branch_pc_sequencer
   import branch_pc_sequencer_pkg::*;
#(
   parameter int unsigned         PC_WIDTH           = PC_WIDTH_DEFAULT,
   parameter int unsigned         THREAD_COUNT       = THREAD_COUNT_DEFAULT,
   parameter int unsigned         THREAD_COUNT_WIDTH = THREAD_COUNT_WIDTH_DEFAULT,
   parameter int unsigned         DETECTOR_COUNT     = DETECTOR_COUNT_DEFAULT,
   parameter logic [PC_WIDTH-1:0] START_PC           = '0
)(
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [DETECTOR_COUNT-1:0]                 reached,
   input  logic [DETECTOR_COUNT-1:0]                 jump,
   input  logic [DETECTOR_COUNT*PC_WIDTH-1:0]        destination,
   input  logic [DETECTOR_COUNT-1:0]                 cancel,
   input  logic                                      IO_ready_current,
   input  logic                                      pc_wren,
   input  logic [THREAD_COUNT_WIDTH-1:0]             pc_wr_thread,
   input  logic [PC_WIDTH-1:0]                       pc_wr_data,
   output logic [PC_WIDTH-1:0]                       pc,
   output logic [THREAD_COUNT_WIDTH-1:0]             pc_thread,
   output logic                                      branch_taken,
   output logic [index_width(DETECTOR_COUNT)-1:0]    branch_index,
   output logic                                      alu_cancel
);

   localparam int unsigned INDEX_WIDTH = index_width(DETECTOR_COUNT);

   logic [THREAD_COUNT_WIDTH-1:0] current_thread;
   logic [PC_WIDTH-1:0]           ring [THREAD_COUNT];
   logic [PC_WIDTH-1:0]           pc_cur;

   logic                          pend_valid;
   logic [THREAD_COUNT_WIDTH-1:0] pend_thread;
   logic [PC_WIDTH-1:0]           pend_data;

   logic [INDEX_WIDTH-1:0]        winner;
   logic                          any_jump;
   logic [PC_WIDTH-1:0]           winner_destination;

   logic                          direct_hit;
   logic                          pend_hit;
   logic                          override_applied;
   pc_src_e                       pc_src;
   logic [PC_WIDTH-1:0]           next_pc;
   logic                          taken_next;
   logic                          cancel_next;

   assign pc_cur = ring[0];

   branch_priority_select #(
      .PC_WIDTH       (PC_WIDTH),
      .DETECTOR_COUNT (DETECTOR_COUNT),
      .INDEX_WIDTH    (INDEX_WIDTH)
   ) u_select (
      .valid              (reached & jump),
      .destination        (destination),
      .winner             (winner),
      .any_jump           (any_jump),
      .winner_destination (winner_destination)
   );

   always_comb begin
      direct_hit       = pc_wren && (pc_wr_thread == current_thread);
      pend_hit         = pend_valid && (pend_thread == current_thread);
      override_applied = direct_hit || pend_hit;

      pc_src = SRC_INC;
      if (override_applied)      pc_src = SRC_OVERRIDE;
      else if (!IO_ready_current) pc_src = SRC_HOLD;
      else if (any_jump)         pc_src = SRC_JUMP;

      next_pc = pc_cur + PC_WIDTH'(1);
      unique case (pc_src)
         SRC_OVERRIDE: next_pc = direct_hit ? pc_wr_data : pend_data;
         SRC_HOLD:     next_pc = pc_cur;
         SRC_JUMP:     next_pc = winner_destination;
         default:      next_pc = pc_cur + PC_WIDTH'(1);
      endcase

      taken_next  = any_jump && IO_ready_current && !override_applied;
      cancel_next = (|(reached & cancel)) && IO_ready_current;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < THREAD_COUNT; i++) ring[i] <= START_PC;
         current_thread <= '0;
         pend_valid     <= 1'b0;
         pend_thread    <= '0;
         pend_data      <= '0;
         pc             <= START_PC;
         pc_thread      <= '0;
         branch_taken   <= 1'b0;
         branch_index   <= '0;
         alu_cancel     <= 1'b0;
      end else begin
         for (int unsigned i = 0; i + 1 < THREAD_COUNT; i++) ring[i] <= ring[i+1];
         ring[THREAD_COUNT-1] <= next_pc;

         current_thread <= (current_thread == THREAD_COUNT_WIDTH'(THREAD_COUNT - 1))
                           ? '0 : current_thread + THREAD_COUNT_WIDTH'(1);

         // A new write to another thread replaces any pending one; a consumed entry is retired.
         if (pc_wren && !direct_hit) begin
            pend_valid  <= 1'b1;
            pend_thread <= pc_wr_thread;
            pend_data   <= pc_wr_data;
         end else if (pend_hit) begin
            pend_valid  <= 1'b0;
         end

         pc           <= next_pc;
         pc_thread    <= current_thread;
         branch_taken <= taken_next;
         branch_index <= winner;
         alu_cancel   <= cancel_next;
      end
   end

endmodule
